pgm_boot_loader: RTL and testbench

//   Serial program loader upstream of the processor fetch stage.
//   - Consumes received UART bytes and assembles 16-bit instruction words.
//   - Writes the words into the instruction RAM through its write port (ADDR/DI/WE).
//   - Holds the processor core in reset until a complete image with a correct checksum has been stored.
//   - Frame: SYNC, LEN_HI, LEN_LO, {W_HI, W_LO} x LEN, CHK.

---
 rtl/pgm_boot_loader.sv | 156 +++++++++++++++
 tb/tb_pgm_boot_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pgm_boot_loader.sv
// Serial program loader: assembles UART bytes into instruction words,
// writes them to instruction RAM and releases the core once the checksum passes.
module pgm_boot_loader #(
   parameter int          ADDR_LEN       = 10,
   parameter int          WORD_LEN       = 16,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          rxData,
   input  logic                rxValid,
   output logic [ADDR_LEN-1:0] ramAddr,
   output logic [WORD_LEN-1:0] ramData,
   output logic                ramWe,
   output logic                coreReset,
   output logic                loadDone,
   output logic                loadErr,
   output logic [ADDR_LEN:0]   wordCount
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_LEN);

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR
   } state_t;

   state_t          state;
   logic [7:0]      chk;
   logic [7:0]      hiByte;
   logic [15:0]     len;
   logic [TW-1:0]   timer;
   logic [15:0]     nextCount;
   logic [15:0]     lenFull;
   logic            isSync;
   logic            timed;

   assign nextCount = 16'(wordCount) + 16'd1;
   assign lenFull   = {len[15:8], rxData};
   assign isSync    = rxValid && (rxData == SYNC_BYTE);
   assign timed     = (state != IDLE) && (state != DONE) && (state != ERR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         chk       <= '0;
         hiByte    <= '0;
         len       <= '0;
         timer     <= '0;
         ramAddr   <= '0;
         ramData   <= '0;
         ramWe     <= 1'b0;
         coreReset <= 1'b1;
         loadDone  <= 1'b0;
         loadErr   <= 1'b0;
         wordCount <= '0;
      end else begin
         ramWe <= 1'b0;
         unique case (state)
            IDLE: begin
               if (isSync) begin
                  state     <= LEN_HI;
                  chk       <= '0;
                  wordCount <= '0;
               end
            end
            LEN_HI: begin
               if (rxValid) begin
                  len[15:8] <= rxData;
                  chk       <= chk ^ rxData;
                  state     <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (rxValid) begin
                  len[7:0] <= rxData;
                  chk      <= chk ^ rxData;
                  if (lenFull == 16'd0 || {1'b0, lenFull} > MAX_LEN) begin
                     state    <= ERR;
                     loadErr  <= 1'b1;
                     loadDone <= 1'b0;
                  end else begin
                     state <= DATA_HI;
                  end
               end
            end
            DATA_HI: begin
               if (rxValid) begin
                  hiByte <= rxData;
                  chk    <= chk ^ rxData;
                  state  <= DATA_LO;
               end
            end
            DATA_LO: begin
               // Write is registered, so it appears the cycle after the low byte.
               if (rxValid) begin
                  chk       <= chk ^ rxData;
                  ramWe     <= 1'b1;
                  ramAddr   <= wordCount[ADDR_LEN-1:0];
                  ramData   <= WORD_LEN'({hiByte, rxData});
                  wordCount <= wordCount + 1'b1;
                  state     <= (nextCount == len) ? CHECK : DATA_HI;
               end
            end
            CHECK: begin
               if (rxValid) begin
                  if (rxData == chk) begin
                     state    <= DONE;
                     loadDone <= 1'b1;
                     loadErr  <= 1'b0;
                  end else begin
                     state    <= ERR;
                     loadErr  <= 1'b1;
                     loadDone <= 1'b0;
                  end
               end
            end
            DONE: begin
               coreReset <= 1'b0;
               if (isSync) begin
                  state     <= LEN_HI;
                  coreReset <= 1'b1;
                  loadDone  <= 1'b0;
                  chk       <= '0;
                  wordCount <= '0;
               end
            end
            ERR: begin
               coreReset <= 1'b1;
               if (isSync) begin
                  state     <= LEN_HI;
                  loadErr   <= 1'b0;
                  chk       <= '0;
                  wordCount <= '0;
               end
            end
            default: state <= IDLE;
         endcase

         // Expiry only fires on idle cycles, so it never races a byte transition.
         if (!timed || rxValid) begin
            timer <= '0;
         end else if (timer == TMAX) begin
            timer    <= '0;
            state    <= ERR;
            loadErr  <= 1'b1;
            loadDone <= 1'b0;
         end else begin
            timer <= timer + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pgm_boot_loader.sv
// Scoreboard bench for pgm_boot_loader: expected RAM writes are queued
// by the stimulus and checked by an independent write monitor.
module tb_pgm_boot_loader;

   localparam int AL = 10;
   localparam int WL = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    rxData = '0;
   logic          rxValid = 1'b0;
   logic [AL-1:0] ramAddr;
   logic [WL-1:0] ramData;
   logic          ramWe;
   logic          coreReset;
   logic          loadDone;
   logic          loadErr;
   logic [AL:0]   wordCount;

   int compared = 0;
   int mismatched = 0;
   logic [25:0] expQ[$];
   logic [7:0]  txq[$];

   pgm_boot_loader #(
      .ADDR_LEN(AL), .WORD_LEN(WL),
      .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset),
      .rxData(rxData), .rxValid(rxValid),
      .ramAddr(ramAddr), .ramData(ramData), .ramWe(ramWe),
      .coreReset(coreReset), .loadDone(loadDone),
      .loadErr(loadErr), .wordCount(wordCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (ramWe === 1'b1) begin
         compared++;
         if (expQ.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_write: got addr %h data %h expected none",
                     ramAddr, ramData);
         end else begin
            logic [25:0] e;
            e = expQ.pop_front();
            if ({ramAddr, ramData} !== e) begin
               mismatched++;
               $display("FAIL write: got addr %h data %h expected addr %h data %h",
                        ramAddr, ramData, e[25:16], e[15:0]);
            end
         end
      end
   end

   task automatic sendByte(input logic [7:0] b);
      @(negedge clk);
      rxData  = b;
      rxValid = 1'b1;
      @(negedge clk);
      rxValid = 1'b0;
   endtask

   task automatic sendQ();
      while (txq.size() > 0) sendByte(txq.pop_front());
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic status(input string tag, input logic d, input logic e,
                         input logic cr, input int wc);
      check({tag, "_loadDone"}, 32'(loadDone), 32'(d));
      check({tag, "_loadErr"}, 32'(loadErr), 32'(e));
      check({tag, "_coreReset"}, 32'(coreReset), 32'(cr));
      check({tag, "_wordCount"}, 32'(wordCount), 32'(wc));
   endtask

   initial begin
      idle(2);
      status("reset", 0, 0, 1, 0);
      check("reset_ramWe", 32'(ramWe), 0);
      check("reset_ramAddr", 32'(ramAddr), 0);
      check("reset_ramData", 32'(ramData), 0);
      reset = 1'b0;
      idle(2);

      // noise in IDLE, then a good two-word image
      expQ.push_back({10'd0, 16'h1234});
      expQ.push_back({10'd1, 16'hABCD});
      txq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h02, 8'h12, 8'h34,
              8'hAB, 8'hCD, 8'h42};
      sendQ();
      check("done_entry_coreReset", 32'(coreReset), 1);
      idle(2);
      status("good", 1, 0, 0, 2);

      // reload request re-asserts coreReset at once
      sendByte(8'hA5);
      check("reload_coreReset", 32'(coreReset), 1);
      check("reload_loadDone", 32'(loadDone), 0);

      // bad checksum: writes still happen
      expQ.push_back({10'd0, 16'h1234});
      expQ.push_back({10'd1, 16'hABCD});
      txq = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
      sendQ();
      idle(2);
      status("badchk", 0, 1, 1, 2);

      // zero and oversize length
      txq = '{8'hA5, 8'h00, 8'h00};
      sendQ();
      idle(2);
      status("len0", 0, 1, 1, 0);
      txq = '{8'hA5, 8'h04, 8'h01};
      sendQ();
      idle(2);
      status("len1025", 0, 1, 1, 0);

      // timeout inside DATA_LO
      txq = '{8'hA5, 8'h00, 8'h01, 8'h12};
      sendQ();
      check("pre_timeout_loadErr", 32'(loadErr), 0);
      idle(10);
      check("mid_timeout_loadErr", 32'(loadErr), 0);
      idle(10);
      status("timeout", 0, 1, 1, 0);

      expQ.push_back({10'd0, 16'h1234});
      txq = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
      sendQ();
      idle(2);
      status("after_to", 1, 0, 0, 1);

      // async reset between W_HI and W_LO
      txq = '{8'hA5, 8'h00, 8'h01, 8'hAA};
      sendQ();
      check("prereset_coreReset", 32'(coreReset), 1);
      #2 reset = 1'b1;
      #1;
      status("midreset", 0, 0, 1, 0);
      check("midreset_ramWe", 32'(ramWe), 0);
      idle(2);
      reset = 1'b0;
      idle(2);
      expQ.push_back({10'd0, 16'h1234});
      txq = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
      sendQ();
      idle(2);
      status("postreset", 1, 0, 0, 1);

      idle(4);
      check("scoreboard_drained", 32'(expQ.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
